// File: rtl/pirdsp_simd_accumulator_pkg.sv
// Shared definitions for the SIMD accumulator: lane-mode encodings,
// the per-beat control record carried down the pipeline, and lane counting.
package pirdsp_pkg;

  localparam logic [1:0] MODE_16x16 = 2'b00;
  localparam logic [1:0] SUM_8x8    = 2'b01;
  localparam logic [1:0] SUM_4x4    = 2'b10;
  localparam logic [1:0] SUM_2x2    = 2'b11;

  typedef struct packed {
    logic       first;
    logic       last;
    logic       is_signed;
    logic [1:0] mode;
  } beat_ctrl_t;

  function automatic int lanes(input logic [1:0] mode);
    case (mode)
      MODE_16x16: return 1;
      SUM_8x8:    return 2;
      SUM_4x4:    return 4;
      default:    return 8;
    endcase
  endfunction

endpackage

// File: rtl/pirdsp_simd_accumulator_if.sv
// Beat input / burst-total output bundle between the multiplier, the
// accumulator and the DSP output register.
interface pirdsp_simd_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 48
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic              is_signed;
  logic              first;
  logic              last;
  logic [PROD_W-1:0] result_0;
  logic [PROD_W-1:0] result_1;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [1:0]        out_mode;
  logic [7:0]        overflow;

  modport master (
    output in_valid, mode, is_signed, first, last, result_0, result_1, out_ready,
    input  in_ready, out_valid, acc_out, out_mode, overflow
  );

  modport slave (
    input  in_valid, mode, is_signed, first, last, result_0, result_1, out_ready,
    output in_ready, out_valid, acc_out, out_mode, overflow
  );
endinterface

// File: rtl/pirdsp_simd_accumulator_lane_adder.sv
// W-bit adder split into 1/2/4/8 lanes by mode; carries are killed at lane
// boundaries and each lane reports carry-out (unsigned) or signed overflow.
module pirdsp_lane_adder
  import pirdsp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  input  logic         is_signed,
  output logic [W-1:0] sum,
  output logic [7:0]   ovf
);

  localparam int SEG = W / 8;

  // Ripple through eight equal segments; a lane spans 8/N of them.
  always_comb begin
    int         span;
    int         msb;
    logic       carry;
    logic [SEG:0] part;
    sum   = '0;
    ovf   = '0;
    span  = 8 / lanes(mode);
    msb   = 0;
    carry = 1'b0;
    part  = '0;
    for (int k = 0; k < 8; k++) begin
      if (k % span == 0) carry = 1'b0;
      part = {1'b0, a[k*SEG +: SEG]} + {1'b0, b[k*SEG +: SEG]} + {{SEG{1'b0}}, carry};
      sum[k*SEG +: SEG] = part[SEG-1:0];
      carry = part[SEG];
      if (k % span == span - 1) begin
        msb = k * SEG + SEG - 1;
        ovf[k / span] = is_signed ? ((a[msb] == b[msb]) && (part[SEG-1] != a[msb])) : carry;
      end
    end
  end

endmodule

// File: rtl/pirdsp_simd_accumulator.sv
// Final per-lane add of the multiplier partial words, burst accumulation with
// guard bits, and a valid/ready output port holding the burst total.
module pirdsp_simd_accumulator
  import pirdsp_pkg::*;
#(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 48
) (
  input logic                      clk,
  input logic                      reset,
  pirdsp_simd_accumulator_if.slave bus
);

  logic              advance;
  logic              accept;
  logic              s0_valid;
  beat_ctrl_t        s0_ctrl;
  logic [PROD_W-1:0] s0_r0;
  logic [PROD_W-1:0] s0_r1;
  logic [1:0]        burst_mode;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic              s1_valid;
  beat_ctrl_t        s1_ctrl;
  logic [ACC_W-1:0]  s1_ext;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  acc_next;
  logic [7:0]        lane_ovf;
  logic [7:0]        ovf_sticky;
  logic [7:0]        ovf_next;
  logic              load_out;
  logic              out_valid_q;
  logic [ACC_W-1:0]  acc_out_q;
  logic [1:0]        out_mode_q;
  logic [7:0]        overflow_q;

  // A held result freezes every stage so no beat is dropped behind it.
  assign advance       = ~out_valid_q | bus.out_ready;
  assign accept        = bus.in_valid & advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid   <= 1'b0;
      s0_ctrl    <= '0;
      s0_r0      <= '0;
      s0_r1      <= '0;
      burst_mode <= MODE_16x16;
    end else if (advance) begin
      s0_valid <= accept;
      if (accept) begin
        s0_ctrl <= '{first: bus.first, last: bus.last, is_signed: bus.is_signed,
                     mode: bus.first ? bus.mode : burst_mode};
        s0_r0   <= bus.result_0;
        s0_r1   <= bus.result_1;
        if (bus.first) burst_mode <= bus.mode;
      end
    end
  end

  pirdsp_lane_adder #(.W(PROD_W)) u_prod_add (
    .a         (s0_r0),
    .b         (s0_r1),
    .mode      (s0_ctrl.mode),
    .is_signed (s0_ctrl.is_signed),
    .sum       (prod),
    .ovf       ()
  );

  // Widen each product lane into its guard-bit accumulator lane.
  always_comb begin
    int n;
    int pw;
    int aw;
    int lane;
    int off;
    prod_ext = '0;
    n    = lanes(s0_ctrl.mode);
    pw   = PROD_W / n;
    aw   = ACC_W / n;
    lane = 0;
    off  = 0;
    for (int i = 0; i < ACC_W; i++) begin
      lane = i / aw;
      off  = i % aw;
      if (off < pw) prod_ext[i] = prod[lane*pw + off];
      else          prod_ext[i] = s0_ctrl.is_signed & prod[lane*pw + pw - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_ext   <= '0;
    end else if (advance) begin
      s1_valid <= s0_valid;
      s1_ctrl  <= s0_ctrl;
      s1_ext   <= prod_ext;
    end
  end

  pirdsp_lane_adder #(.W(ACC_W)) u_acc_add (
    .a         (acc),
    .b         (s1_ext),
    .mode      (s1_ctrl.mode),
    .is_signed (s1_ctrl.is_signed),
    .sum       (acc_sum),
    .ovf       (lane_ovf)
  );

  assign acc_next = s1_ctrl.first ? s1_ext : acc_sum;
  assign ovf_next = s1_ctrl.first ? 8'h00 : (ovf_sticky | lane_ovf);
  assign load_out = advance & s1_valid & s1_ctrl.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      ovf_sticky  <= '0;
      out_valid_q <= 1'b0;
      acc_out_q   <= '0;
      out_mode_q  <= MODE_16x16;
      overflow_q  <= '0;
    end else begin
      if (advance && s1_valid) begin
        acc        <= acc_next;
        ovf_sticky <= ovf_next;
      end
      if (load_out) begin
        out_valid_q <= 1'b1;
        acc_out_q   <= acc_next;
        out_mode_q  <= s1_ctrl.mode;
        overflow_q  <= ovf_next;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pirdsp_simd_accumulator.sv
// Bench for pirdsp_simd_accumulator: burst table with a result scoreboard,
// plus backpressure and mid-burst reset sequences.
module tb_pirdsp_simd_accumulator;
  import pirdsp_pkg::*;

  typedef struct {
    logic [1:0]  mode;
    logic        is_signed;
    logic [31:0] r0;
    logic [31:0] r1;
    int          beats;
    logic [47:0] exp_acc;
    logic [7:0]  exp_ovf;
  } vec_t;

  typedef struct {
    logic [47:0] acc;
    logic [1:0]  mode;
    logic [7:0]  ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  vec_t vecs[9];
  int   compared = 0;
  int   mismatched = 0;

  pirdsp_simd_accumulator_if #(.PROD_W(32), .ACC_W(48)) bus ();

  pirdsp_simd_accumulator #(.PROD_W(32), .ACC_W(48)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic report_timeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout, required DUT response", name);
  endtask

  task automatic drive_beat(input logic [1:0] mode, input logic is_signed, input logic first,
                            input logic last, input logic [31:0] r0, input logic [31:0] r1);
    int budget;
    budget        = 0;
    bus.mode      = mode;
    bus.is_signed = is_signed;
    bus.first     = first;
    bus.last      = last;
    bus.result_0  = r0;
    bus.result_1  = r1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) report_timeout("in_ready_wait");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Non-first beats carry an inverted mode so that mode latching is exercised.
  task automatic apply_stimulus(input vec_t v);
    for (int b = 0; b < v.beats; b++) begin
      logic f;
      logic l;
      f = (b == 0);
      l = (b == v.beats - 1);
      if (l) sb.push_back('{acc: v.exp_acc, mode: v.mode, ovf: v.exp_ovf});
      drive_beat(f ? v.mode : ~v.mode, v.is_signed, f, l, v.r0, v.r1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) report_timeout("scoreboard_drain");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got acc_out %0h, required no output", bus.acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("acc_out", bus.acc_out, e.acc);
        check_output("out_mode", bus.out_mode, e.mode);
        check_output("overflow", bus.overflow, e.ovf);
      end
    end
  end

  initial begin
    vecs[0] = '{MODE_16x16, 1'b0, 32'h00000010, 32'h00000020, 3,  48'h000000000090, 8'h00};
    vecs[1] = '{MODE_16x16, 1'b0, 32'hFFFFFFFF, 32'h11111111, 1,  48'h000011111110, 8'h00};
    vecs[2] = '{SUM_2x2,    1'b0, 32'hFFFFFFFF, 32'h11111111, 1,  48'h000000000000, 8'h00};
    vecs[3] = '{SUM_2x2,    1'b1, 32'hFFFFFFFF, 32'h00000000, 4,  48'hF3CF3CF3CF3C, 8'h00};
    vecs[4] = '{SUM_4x4,    1'b0, 32'hFFFFFFFF, 32'h00000000, 17, 48'h0EF0EF0EF0EF, 8'h0F};
    vecs[5] = '{SUM_2x2,    1'b1, 32'h77777777, 32'h00000000, 5,  48'h8E38E38E38E3, 8'hFF};
    vecs[6] = '{SUM_8x8,    1'b0, 32'h00010002, 32'h00030004, 2,  48'h00000800000C, 8'h00};
    vecs[7] = '{MODE_16x16, 1'b1, 32'h80000000, 32'h00000000, 1,  48'hFFFF80000000, 8'h00};
    vecs[8] = '{SUM_8x8,    1'b1, 32'hFFFF0000, 32'h0000FFFF, 3,  48'hFFFFFDFFFFFD, 8'h00};

    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.is_signed = 1'b0;
    bus.first     = 1'b0;
    bus.last      = 1'b0;
    bus.result_0  = '0;
    bus.result_1  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("reset_in_ready", bus.in_ready, 1'b1);
    check_output("reset_out_valid", bus.out_valid, 1'b0);
    check_output("reset_acc_out", bus.acc_out, 48'h0);
    check_output("reset_out_mode", bus.out_mode, 2'b00);
    check_output("reset_overflow", bus.overflow, 8'h00);
    bus.out_ready = 1'b1;

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);
    wait_drain();

    $display("[TB] backpressure sequence");
    bus.out_ready = 1'b0;
    fork
      begin
        apply_stimulus('{MODE_16x16, 1'b0, 32'h5, 32'h5, 2, 48'h000000000014, 8'h00});
        apply_stimulus('{SUM_8x8, 1'b0, 32'h00020001, 32'h0, 3, 48'h000006000003, 8'h00});
      end
      begin
        int budget;
        budget = 0;
        while (!bus.out_valid && budget < 100) begin
          @(negedge clk);
          budget++;
        end
        if (!bus.out_valid) report_timeout("bp_out_valid_wait");
        repeat (5) begin
          @(negedge clk);
          check_output("bp_acc_hold", bus.acc_out, 48'h000000000014);
          check_output("bp_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    $display("[TB] mid-burst reset sequence");
    drive_beat(MODE_16x16, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive_beat(MODE_16x16, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("midreset_out_valid", bus.out_valid, 1'b0);
    check_output("midreset_acc_out", bus.acc_out, 48'h0);
    check_output("midreset_out_mode", bus.out_mode, 2'b00);
    check_output("midreset_overflow", bus.overflow, 8'h00);
    check_output("midreset_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("midreset_discarded", bus.out_valid, 1'b0);
    apply_stimulus('{MODE_16x16, 1'b0, 32'h3, 32'h4, 2, 48'h00000000000E, 8'h00});
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
